ins_fetcher: RTL and testbench



---
 rtl/ins_fetcher_pkg.sv | 16 +
 rtl/ins_fetcher_branch_predictor.sv | 27 ++
 rtl/ins_fetcher.sv | 113 +++++++++++
 tb/tb_ins_fetcher.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_fetcher_pkg.sv
// ins_fetcher_pkg: opcodes, FSM state codes and immediate decoders shared by the fetch unit
package ins_fetcher_pkg;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam int BHT_BITS_DEF = 6;
   localparam logic [1:0] ST_REQ       = 2'd0;
   localparam logic [1:0] ST_PRESENT   = 2'd1;
   localparam logic [1:0] ST_JALR_WAIT = 2'd2;
   function automatic logic [31:0] imm_j(input logic [31:0] i);
      return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
   endfunction
   function automatic logic [31:0] imm_b(input logic [31:0] i);
      return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
   endfunction
endpackage

// File: rtl/ins_fetcher_branch_predictor.sv
// ins_fetcher_branch_predictor: table of 2-bit saturating counters with one read and one update port
module ins_fetcher_branch_predictor
   import ins_fetcher_pkg::*;
#(
   parameter int BHT_BITS = BHT_BITS_DEF
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                en,
   input  logic [BHT_BITS-1:0] rd_idx,
   output logic                rd_taken,
   input  logic                upd_valid,
   input  logic [BHT_BITS-1:0] upd_idx,
   input  logic                upd_taken
);
   logic [1:0] bht [2**BHT_BITS];
   logic [1:0] cur;
   assign cur = bht[upd_idx];
   assign rd_taken = bht[rd_idx][1];
   // counters start weakly not-taken and saturate at 0 and 3; reads see the pre-update value
   always_ff @(posedge clk_in) begin
      if (rst_in)
         for (int i = 0; i < 2**BHT_BITS; i++) bht[i] <= 2'b01;
      else if (en && upd_valid)
         bht[upd_idx] <= upd_taken ? cur + {1'b0, cur != 2'b11} : cur - {1'b0, cur != 2'b00};
   end
endmodule

// File: rtl/ins_fetcher.sv
// ins_fetcher: PC/fetch FSM with next-PC prediction and decoder handshake
module ins_fetcher
   import ins_fetcher_pkg::*;
#(
   parameter int          BHT_BITS = BHT_BITS_DEF,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic        icache_req_valid,
   output logic [31:0] icache_addr,
   input  logic        icache_resp_valid,
   input  logic [31:0] icache_data,
   output logic        ins_ready,
   output logic [31:0] ins,
   output logic [31:0] pc,
   output logic [31:0] predict_nxt_pc,
   input  logic        IFetcher_stall,
   input  logic        IFetcher_clear,
   input  logic [31:0] IFetcher_new_addr,
   input  logic        rob_flush,
   input  logic [31:0] rob_flush_addr,
   input  logic        br_update_valid,
   input  logic [31:0] br_update_pc,
   input  logic        br_update_taken
);
   logic [1:0]  state;
   logic [31:0] fpc;
   logic [31:1] pc_q;
   logic        taken, discard, is_jalr, hold_valid;
   logic [31:0] hold_data;
   logic        resp_v, bht_taken, br_taken, cap_taken;
   logic [31:0] resp_d, cap_next;
   logic [6:0]  op;

   ins_fetcher_branch_predictor #(.BHT_BITS(BHT_BITS)) u_bp (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .en        (rdy_in),
      .rd_idx    (BHT_BITS'(fpc >> 2)),
      .rd_taken  (bht_taken),
      .upd_valid (br_update_valid),
      .upd_idx   (BHT_BITS'(br_update_pc >> 2)),
      .upd_taken (br_update_taken)
   );

   assign resp_v    = hold_valid | icache_resp_valid;
   assign resp_d    = hold_valid ? hold_data : icache_data;
   assign op        = resp_d[6:0];
   assign br_taken  = op == OP_BR && bht_taken;
   assign cap_taken = op == OP_JAL || br_taken;
   assign cap_next  = fpc + (op == OP_JAL ? imm_j(resp_d) : br_taken ? imm_b(resp_d) : 32'd4);

   assign icache_req_valid = state == ST_REQ && !hold_valid && !rst_in;
   assign icache_addr      = fpc;
   assign ins_ready        = state == ST_PRESENT;
   assign pc               = {pc_q, taken};

   // a response arriving while paused is parked here until rdy_in returns
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (rdy_in)
         hold_valid <= 1'b0;
      else if (icache_resp_valid && state == ST_REQ && !hold_valid) begin
         hold_valid <= 1'b1;
         hold_data  <= icache_data;
      end
   end

   // fetch FSM: flush beats JALR resolve beats acceptance beats response capture
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state          <= ST_REQ;
         fpc            <= RESET_PC;
         discard        <= 1'b0;
         is_jalr        <= 1'b0;
         ins            <= '0;
         pc_q           <= '0;
         taken          <= 1'b0;
         predict_nxt_pc <= '0;
      end else if (rdy_in) begin
         if (rob_flush) begin
            state   <= ST_REQ;
            fpc     <= rob_flush_addr;
            discard <= state == ST_REQ && !resp_v;
         end else if (state == ST_JALR_WAIT) begin
            if (IFetcher_clear) begin
               fpc   <= IFetcher_new_addr & ~32'd1;
               state <= ST_REQ;
            end
         end else if (state == ST_PRESENT) begin
            if (!IFetcher_stall) begin
               state <= is_jalr ? ST_JALR_WAIT : ST_REQ;
               if (!is_jalr) fpc <= predict_nxt_pc;
            end
         end else if (resp_v) begin
            if (discard)
               discard <= 1'b0;
            else begin
               state          <= ST_PRESENT;
               ins            <= resp_d;
               pc_q           <= fpc[31:1];
               taken          <= cap_taken;
               predict_nxt_pc <= cap_next;
               is_jalr        <= op == OP_JALR;
            end
         end
      end
   end
endmodule

// File: tb/tb_ins_fetcher.sv
// tb_ins_fetcher: vector table, directed corner sequences and randomized fetch stream against a behavioural model
module tb_ins_fetcher;
   logic        clk_in = 0, rst_in = 1, rdy_in = 1;
   logic        icache_req_valid, icache_resp_valid = 0;
   logic [31:0] icache_addr, icache_data = 0;
   logic        ins_ready;
   logic [31:0] ins, pc, predict_nxt_pc;
   logic        IFetcher_stall = 0, IFetcher_clear = 0;
   logic [31:0] IFetcher_new_addr = 0;
   logic        rob_flush = 0;
   logic [31:0] rob_flush_addr = 0;
   logic        br_update_valid = 0, br_update_taken = 0;
   logic [31:0] br_update_pc = 0;

   ins_fetcher dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .icache_req_valid(icache_req_valid), .icache_addr(icache_addr),
      .icache_resp_valid(icache_resp_valid), .icache_data(icache_data),
      .ins_ready(ins_ready), .ins(ins), .pc(pc), .predict_nxt_pc(predict_nxt_pc),
      .IFetcher_stall(IFetcher_stall), .IFetcher_clear(IFetcher_clear),
      .IFetcher_new_addr(IFetcher_new_addr), .rob_flush(rob_flush),
      .rob_flush_addr(rob_flush_addr), .br_update_valid(br_update_valid),
      .br_update_pc(br_update_pc), .br_update_taken(br_update_taken)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0, errors = 0;
   int bht_m [64];
   logic [31:0] exp_addr;

   typedef struct {
      logic [31:0] w;
      logic [31:0] addr;
      logic        taken;
      logic [31:0] next;
   } vec_t;
   vec_t tbl [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   function automatic int bidx(input logic [31:0] a);
      return int'((a >> 2) & 32'd63);
   endfunction

   function automatic void model_update(input logic [31:0] a, input logic t);
      if (t && bht_m[bidx(a)] < 3) bht_m[bidx(a)]++;
      if (!t && bht_m[bidx(a)] > 0) bht_m[bidx(a)]--;
   endfunction

   function automatic void predict(input logic [31:0] a, input logic [31:0] w,
                                   output logic [31:0] nx, output logic tk);
      int off;
      int op;
      op  = int'(w & 32'h7F);
      off = 4;
      tk  = 0;
      if (op == 'h6F) begin
         off = int'((w >> 21) & 32'h3FF) * 2 + int'((w >> 20) & 32'd1) * 2048
             + int'((w >> 12) & 32'hFF) * 4096 - int'(w >> 31) * 1048576;
         tk = 1;
      end else if (op == 'h63 && bht_m[bidx(a)] >= 2) begin
         off = int'((w >> 8) & 32'hF) * 2 + int'((w >> 25) & 32'h3F) * 32
             + int'((w >> 7) & 32'd1) * 2048 - int'(w >> 31) * 4096;
         tk = 1;
      end
      nx = a + 32'(off);
   endfunction

   task automatic wait_req;
      int n = 0;
      while (!icache_req_valid && n < 20) begin
         tick;
         n++;
      end
      chk("req_wait", {31'd0, icache_req_valid}, 1);
   endtask

   task automatic fetch(input logic [31:0] w, input logic uv, input logic [31:0] upc, input logic ut,
                        output logic [31:0] nx, output logic tk);
      wait_req;
      chk("fetch_addr", icache_addr, exp_addr);
      predict(exp_addr, w, nx, tk);
      icache_resp_valid = 1;
      icache_data       = w;
      br_update_valid   = uv;
      br_update_pc      = upc;
      br_update_taken   = ut;
      tick;
      icache_resp_valid = 0;
      br_update_valid   = 0;
      if (uv) model_update(upc, ut);
      chk("ins_ready", {31'd0, ins_ready}, 1);
      chk("ins", ins, w);
      chk("pc", pc, {exp_addr[31:1], tk});
      chk("pnp", predict_nxt_pc, nx);
   endtask

   task automatic accept_next(input logic [31:0] nx);
      tick;
      chk("req_after_accept", {31'd0, icache_req_valid}, 1);
      exp_addr = nx;
      chk("addr_after_accept", icache_addr, exp_addr);
   endtask

   task automatic redirect(input logic [31:0] a);
      rob_flush      = 1;
      rob_flush_addr = a;
      tick;
      rob_flush = 0;
      chk("redirect_ready", {31'd0, ins_ready}, 0);
      exp_addr = a;
      chk("redirect_addr", icache_addr, exp_addr);
   endtask

   task automatic br_commit(input logic [31:0] a, input logic t);
      br_update_valid = 1;
      br_update_pc    = a;
      br_update_taken = t;
      tick;
      br_update_valid = 0;
      model_update(a, t);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] nx, w, upc, na;
      logic        tk;
      int          k, s;
      for (int i = 0; i < 64; i++) bht_m[i] = 1;
      tbl[0] = '{32'h00000013, 32'h00, 1'b0, 32'h04};
      tbl[1] = '{32'h0100006F, 32'h04, 1'b1, 32'h14};
      tbl[2] = '{32'hFF9FF06F, 32'h14, 1'b1, 32'h0C};
      tbl[3] = '{32'h00000463, 32'h0C, 1'b0, 32'h10};
      tbl[4] = '{32'h123450B7, 32'h10, 1'b0, 32'h14};

      tick;
      tick;
      chk("rst_req", {31'd0, icache_req_valid}, 0);
      chk("rst_addr", icache_addr, 0);
      chk("rst_ready", {31'd0, ins_ready}, 0);
      chk("rst_ins", ins, 0);
      chk("rst_pc", pc, 0);
      chk("rst_pnp", predict_nxt_pc, 0);
      rst_in = 0;
      tick;
      chk("req_after_rst", {31'd0, icache_req_valid}, 1);
      exp_addr = 0;

      for (int i = 0; i < 5; i++) begin
         fetch(tbl[i].w, 0, 0, 0, nx, tk);
         chk("tbl_pc", pc, {tbl[i].addr[31:1], tbl[i].taken});
         chk("tbl_next", predict_nxt_pc, tbl[i].next);
         accept_next(nx);
      end

      fetch(32'h00000013, 0, 0, 0, nx, tk);
      IFetcher_stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("stall_ready", {31'd0, ins_ready}, 1);
         chk("stall_ins", ins, 32'h13);
         chk("stall_pc", pc, 32'h14);
         chk("stall_pnp", predict_nxt_pc, 32'h18);
         chk("stall_noreq", {31'd0, icache_req_valid}, 0);
      end
      IFetcher_stall = 0;
      accept_next(32'h18);

      IFetcher_clear    = 1;
      IFetcher_new_addr = 32'h501;
      tick;
      IFetcher_clear = 0;
      chk("clear_ignored", icache_addr, 32'h18);

      rob_flush      = 1;
      rob_flush_addr = 32'h200;
      tick;
      rob_flush = 0;
      chk("flush_req", {31'd0, icache_req_valid}, 1);
      chk("flush_addr", icache_addr, 32'h200);
      icache_resp_valid = 1;
      icache_data       = 32'h0100006F;
      tick;
      icache_resp_valid = 0;
      chk("stale_dropped", {31'd0, ins_ready}, 0);
      tick;
      chk("stale_dropped2", {31'd0, ins_ready}, 0);
      chk("refetch_addr", icache_addr, 32'h200);
      exp_addr = 32'h200;
      fetch(32'h00000013, 0, 0, 0, nx, tk);
      accept_next(nx);

      icache_resp_valid = 1;
      icache_data       = 32'h00000013;
      rob_flush         = 1;
      rob_flush_addr    = 32'h300;
      tick;
      icache_resp_valid = 0;
      rob_flush         = 0;
      chk("flush_resp_drop", {31'd0, ins_ready}, 0);
      chk("flush_resp_addr", icache_addr, 32'h300);
      exp_addr = 32'h300;
      fetch(32'h00000013, 0, 0, 0, nx, tk);

      redirect(32'h8);
      fetch(32'h0100006F, 0, 0, 0, nx, tk);
      chk("jal_pc", pc, 32'h9);
      chk("jal_pnp", predict_nxt_pc, 32'h18);
      accept_next(nx);
      chk("jal_addr", icache_addr, 32'h18);
      fetch(32'h00000013, 0, 0, 0, nx, tk);

      redirect(32'h20);
      fetch(32'h04000063, 0, 0, 0, nx, tk);
      chk("beq_nt_pc", pc, 32'h20);
      chk("beq_nt_pnp", predict_nxt_pc, 32'h24);
      accept_next(nx);
      chk("beq_nt_addr", icache_addr, 32'h24);
      br_commit(32'h20, 1);
      br_commit(32'h20, 1);
      fetch(32'h00000013, 0, 0, 0, nx, tk);
      redirect(32'h20);
      fetch(32'h04000063, 0, 0, 0, nx, tk);
      chk("beq_t_pc", pc, 32'h21);
      chk("beq_t_pnp", predict_nxt_pc, 32'h60);
      accept_next(nx);

      fetch(32'h00008067, 0, 0, 0, nx, tk);
      chk("jalr_pc", pc, 32'h60);
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("jalr_noreq", {31'd0, icache_req_valid}, 0);
         chk("jalr_noready", {31'd0, ins_ready}, 0);
      end
      IFetcher_clear    = 1;
      IFetcher_new_addr = 32'h101;
      tick;
      IFetcher_clear = 0;
      chk("jalr_req", {31'd0, icache_req_valid}, 1);
      chk("jalr_addr", icache_addr, 32'h100);
      exp_addr = 32'h100;

      fetch(32'h00000013, 0, 0, 0, nx, tk);
      rdy_in = 0;
      tick;
      chk("pause_no_accept", {31'd0, ins_ready}, 1);
      rdy_in = 1;
      accept_next(32'h104);
      rdy_in            = 0;
      icache_resp_valid = 1;
      icache_data       = 32'h00100093;
      tick;
      icache_resp_valid = 0;
      tick;
      chk("pause_ready", {31'd0, ins_ready}, 0);
      chk("pause_noreq", {31'd0, icache_req_valid}, 0);
      rdy_in = 1;
      tick;
      chk("hold_ready", {31'd0, ins_ready}, 1);
      chk("hold_ins", ins, 32'h00100093);
      chk("hold_pc", pc, 32'h104);
      accept_next(32'h108);

      for (int n = 0; n < 60; n++) begin
         k = $urandom_range(0, 5);
         w = $urandom;
         w[6:0] = k == 2 ? 7'h6F : (k == 3 || k == 4) ? 7'h63 : k == 5 ? 7'h67 : 7'h13;
         upc = $urandom_range(0, 1) ? exp_addr : 32'($urandom_range(0, 63)) << 2;
         fetch(w, 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)), nx, tk);
         s = $urandom_range(0, 2);
         IFetcher_stall = 1;
         for (int j = 0; j < s; j++) begin
            tick;
            chk("rnd_stall_pnp", predict_nxt_pc, nx);
            chk("rnd_stall_noreq", {31'd0, icache_req_valid}, 0);
         end
         IFetcher_stall = 0;
         if (k == 5) begin
            tick;
            chk("rnd_jalr_noreq", {31'd0, icache_req_valid}, 0);
            na                = $urandom;
            IFetcher_clear    = 1;
            IFetcher_new_addr = na;
            tick;
            IFetcher_clear = 0;
            exp_addr = na & ~32'd1;
            chk("rnd_jalr_addr", icache_addr, exp_addr);
         end else
            accept_next(nx);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
